// File: rtl/uart_tx_buffer.sv
// Byte FIFO and handshake sequencer in front of the UART transmitter.
// Producers push single-cycle byte writes; the drain FSM presents one byte at
// a time on uart_din, raises uart_en until the transmitter reports busy, waits
// for the frame to finish, then keeps uart_en low for a guard gap so the
// transmitter's two-flop edge detector sees a clean rising edge next time.
module uart_tx_buffer #(
  parameter int DEPTH        = 16,
  parameter int ADDR_W       = 4,
  parameter int BUSY_TIMEOUT = 15,
  parameter int GAP_CYCLES   = 2
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
  input  logic              wr_en,
  input  logic [7:0]        wr_data,
  output logic              full,
  output logic              empty,
  output logic [ADDR_W:0]   count,
  output logic              overflow,
  output logic              timeout_err,
  input  logic              clr_err,
  output logic              uart_en,
  output logic [7:0]        uart_din,
  input  logic              uart_tx_busy
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ASSERT = 2'd1;
  localparam logic [1:0] S_WAIT   = 2'd2;
  localparam logic [1:0] S_GAP    = 2'd3;

  localparam int TMR_W = $clog2(BUSY_TIMEOUT + 1);
  localparam int GAP_W = $clog2(GAP_CYCLES + 1);

  localparam logic [ADDR_W:0] DEPTH_C   = (ADDR_W + 1)'(DEPTH);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(BUSY_TIMEOUT);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);

  logic [7:0]        mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic [1:0]        state;
  logic [TMR_W-1:0]  timer;
  logic [GAP_W-1:0]  gap_cnt;

  logic wr_accept;
  logic pop;
  logic timeout_evt;

  // full/empty decode the registered occupancy, so a write sees last cycle's full
  assign full  = (count == DEPTH_C);
  assign empty = (count == '0);

  assign wr_accept   = wr_en && !full;
  assign pop         = (state == S_IDLE) && !empty;
  assign timeout_evt = (state == S_ASSERT) && !uart_tx_busy && (timer == TMR_LAST);

  // Storage array: data only, no reset needed
  always_ff @(posedge sys_clk) begin
    if (wr_accept) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  // Pointers wrap naturally at DEPTH; occupancy kept in its own register
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_accept) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({wr_accept, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Sticky error flags; a new event in the same cycle as clr_err keeps the flag set
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      overflow    <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      if (wr_en && full) begin
        overflow <= 1'b1;
      end else if (clr_err) begin
        overflow <= 1'b0;
      end
      if (timeout_evt) begin
        timeout_err <= 1'b1;
      end else if (clr_err) begin
        timeout_err <= 1'b0;
      end
    end
  end

  // Drain sequencer: pop, request, wait for the frame, then hold the guard gap
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state    <= S_IDLE;
      uart_en  <= 1'b0;
      uart_din <= 8'h00;
      timer    <= '0;
      gap_cnt  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          uart_en <= 1'b0;
          if (!empty) begin
            uart_din <= mem[rd_ptr];
            timer    <= '0;
            state    <= S_ASSERT;
          end
        end
        S_ASSERT: begin
          // A busy flag already high here counts as the handshake
          if (uart_tx_busy) begin
            uart_en <= 1'b0;
            state   <= S_WAIT;
          end else if (timer == TMR_LAST) begin
            uart_en <= 1'b0;
            gap_cnt <= '0;
            state   <= S_GAP;
          end else begin
            uart_en <= 1'b1;
            timer   <= timer + 1'b1;
          end
        end
        S_WAIT: begin
          uart_en <= 1'b0;
          if (!uart_tx_busy) begin
            gap_cnt <= '0;
            state   <= S_GAP;
          end
        end
        S_GAP: begin
          uart_en <= 1'b0;
          if (gap_cnt == GAP_LAST) begin
            state <= S_IDLE;
          end else begin
            gap_cnt <= gap_cnt + 1'b1;
          end
        end
        default: begin
          uart_en <= 1'b0;
          state   <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_buffer.sv
// Bench for uart_tx_buffer: a behavioural transmitter (two-flop edge detect,
// 16 clocks per bit) drives the serial line, a receiver decodes frames and a
// scoreboard compares them against the queue of bytes the producer wrote.
module tb_uart_tx_buffer;
  localparam int DEPTH        = 16;
  localparam int ADDR_W       = 4;
  localparam int BUSY_TIMEOUT = 15;
  localparam int GAP_CYCLES   = 2;
  localparam int BIT_CLKS     = 16;

  logic              sys_clk = 1'b0;
  logic              sys_rst = 1'b1;
  logic              wr_en   = 1'b0;
  logic [7:0]        wr_data = 8'h00;
  logic              clr_err = 1'b0;
  logic              full;
  logic              empty;
  logic [ADDR_W:0]   count;
  logic              overflow;
  logic              timeout_err;
  logic              uart_en;
  logic [7:0]        uart_din;
  logic              uart_tx_busy;

  int n_cmp  = 0;
  int n_fail = 0;
  logic [7:0] exp_q[$];
  int busy_mode = 0;   // 0: transmitter model, 1: busy stuck high, 2: busy stuck low
  int max_count = 0;

  // transmitter model state
  logic       en_d1 = 1'b0;
  logic       en_d2 = 1'b0;
  logic       tx_active = 1'b0;
  logic [9:0] sh = 10'h3FF;
  logic [3:0] bit_i = 4'd0;
  logic [4:0] clk_i = 5'd0;
  logic       txd;

  uart_tx_buffer #(
    .DEPTH(DEPTH), .ADDR_W(ADDR_W), .BUSY_TIMEOUT(BUSY_TIMEOUT), .GAP_CYCLES(GAP_CYCLES)
  ) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .wr_en(wr_en), .wr_data(wr_data),
    .full(full), .empty(empty), .count(count), .overflow(overflow),
    .timeout_err(timeout_err), .clr_err(clr_err), .uart_en(uart_en),
    .uart_din(uart_din), .uart_tx_busy(uart_tx_busy)
  );

  always #5 sys_clk = ~sys_clk;

  assign uart_tx_busy = (busy_mode == 1) ? 1'b1 : (busy_mode == 2) ? 1'b0 : tx_active;
  assign txd = tx_active ? sh[bit_i] : 1'b1;

  // transmitter: edge-detect uart_en through two flops, then shift a 10-bit frame
  always @(posedge sys_clk) begin
    en_d1 <= uart_en;
    en_d2 <= en_d1;
    if (tx_active) begin
      if (clk_i == 5'(BIT_CLKS - 1)) begin
        clk_i <= 5'd0;
        if (bit_i == 4'd9) tx_active <= 1'b0;
        else bit_i <= bit_i + 4'd1;
      end else begin
        clk_i <= clk_i + 5'd1;
      end
    end else if (busy_mode == 0 && en_d1 && !en_d2) begin
      sh        <= {1'b1, uart_din, 1'b0};
      tx_active <= 1'b1;
      bit_i     <= 4'd0;
      clk_i     <= 5'd0;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // receiver + scoreboard monitor
  initial begin
    logic [7:0] b;
    logic [7:0] e;
    b = 8'h00;
    forever begin
      @(negedge sys_clk);
      if (txd == 1'b0) begin
        repeat (8) @(negedge sys_clk);
        for (int k = 0; k < 8; k++) begin
          repeat (BIT_CLKS) @(negedge sys_clk);
          b[k] = txd;
        end
        repeat (BIT_CLKS) @(negedge sys_clk);
        check("stop_bit", {31'd0, txd}, 32'd1);
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL unexpected_byte: got %0h expected none", b);
        end else begin
          e = exp_q.pop_front();
          check("byte_order", {24'd0, b}, {24'd0, e});
        end
      end
    end
  end

  // uart_en low-time between requests, and occupancy high-water mark
  initial begin
    logic prev;
    int   low;
    bit   seen;
    prev = 1'b0; low = 0; seen = 1'b0;
    forever begin
      @(negedge sys_clk);
      if (sys_rst) begin
        prev = 1'b0; low = 0; seen = 1'b0;
      end else begin
        if (int'(count) > max_count) max_count = int'(count);
        if (uart_en && !prev && seen) check("en_gap", {31'd0, low >= GAP_CYCLES}, 32'd1);
        if (!uart_en) low++;
        else begin
          low  = 0;
          seen = 1'b1;
        end
        prev = uart_en;
      end
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  // one write per call; caller sits on a negedge
  task automatic put(input logic [7:0] d);
    wr_en   = 1'b1;
    wr_data = d;
    @(negedge sys_clk);
    wr_en   = 1'b0;
  endtask

  // keep outstanding bytes below DEPTH so every write is accepted
  task automatic throttle();
    int n;
    n = 0;
    while (exp_q.size() >= DEPTH && n < 5000) begin
      @(negedge sys_clk);
      n++;
    end
    if (n >= 5000) check("throttle_bound", 32'd0, 32'd1);
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (!(exp_q.size() == 0 && empty && !tx_active) && n < 20000) begin
      @(negedge sys_clk);
      n++;
    end
    if (n >= 20000) check(name, 32'd0, 32'd1);
    repeat (10) @(negedge sys_clk);
  endtask

  initial begin
    logic [7:0] d;
    int hi;
    int n;

    // reset state
    repeat (3) @(negedge sys_clk);
    check("rst_count", {27'd0, count}, 32'd0);
    check("rst_empty", {31'd0, empty}, 32'd1);
    check("rst_full", {31'd0, full}, 32'd0);
    check("rst_en", {31'd0, uart_en}, 32'd0);
    check("rst_din", {24'd0, uart_din}, 32'd0);
    check("rst_flags", {30'd0, overflow, timeout_err}, 32'd0);
    sys_rst = 1'b0;
    @(negedge sys_clk);

    // single byte and request latency
    exp_q.push_back(8'h35);
    put(8'h35);
    check("lat_en_n0", {31'd0, uart_en}, 32'd0);
    @(negedge sys_clk);
    check("lat_en_n1", {31'd0, uart_en}, 32'd0);
    check("lat_din_n1", {24'd0, uart_din}, 32'h35);
    @(negedge sys_clk);
    check("lat_en_n2", {31'd0, uart_en}, 32'd1);
    wait_idle("single_drain");
    check("single_empty", {31'd0, empty}, 32'd1);
    check("single_flags", {30'd0, overflow, timeout_err}, 32'd0);

    // short burst
    exp_q.push_back(8'h0D); exp_q.push_back(8'h0A); exp_q.push_back(8'h39);
    put(8'h0D); put(8'h0A); put(8'h39);
    wait_idle("burst_drain");
    check("burst_count", {27'd0, count}, 32'd0);

    // 40 bytes in bursts of 10 across pointer wrap
    for (int bst = 0; bst < 4; bst++) begin
      for (int i = 0; i < 10; i++) begin
        throttle();
        d = 8'(8'h40 + bst * 10 + i);
        exp_q.push_back(d);
        put(d);
      end
      repeat ($urandom_range(0, 40)) @(negedge sys_clk);
    end
    wait_idle("wrap_drain");

    // randomized data and spacing
    for (int i = 0; i < 60; i++) begin
      throttle();
      d = 8'($urandom_range(0, 255));
      exp_q.push_back(d);
      put(d);
      if ($urandom_range(0, 9) == 0) repeat ($urandom_range(0, 300)) @(negedge sys_clk);
      else repeat ($urandom_range(0, 3)) @(negedge sys_clk);
    end
    wait_idle("rand_drain");

    // overflow with the transmitter stalled: the first byte is consumed by the
    // stale-busy handshake, the next DEPTH fill the FIFO, the last is dropped
    busy_mode = 1;
    for (int i = 0; i < DEPTH + 2; i++) put(8'(i));
    check("ovf_count", {27'd0, count}, DEPTH);
    check("ovf_full", {31'd0, full}, 32'd1);
    check("ovf_flag", {31'd0, overflow}, 32'd1);
    wr_en = 1'b1; wr_data = 8'hEE; clr_err = 1'b1;
    @(negedge sys_clk);
    wr_en = 1'b0; clr_err = 1'b0;
    check("ovf_set_wins", {31'd0, overflow}, 32'd1);
    clr_err = 1'b1;
    @(negedge sys_clk);
    clr_err = 1'b0;
    check("ovf_cleared", {31'd0, overflow}, 32'd0);
    check("ovf_still_full", {31'd0, full}, 32'd1);
    for (int i = 1; i <= DEPTH; i++) exp_q.push_back(8'(i));
    busy_mode = 0;
    wait_idle("ovf_drain");
    check("ovf_end_count", {27'd0, count}, 32'd0);

    // busy never rises
    busy_mode = 2;
    put(8'hA5);
    n = 0;
    while (!uart_en && n < 100) begin
      @(negedge sys_clk);
      n++;
    end
    hi = 0;
    while (uart_en && hi < 100) begin
      hi++;
      @(negedge sys_clk);
    end
    check("to_en_cycles", hi, BUSY_TIMEOUT);
    check("to_flag", {31'd0, timeout_err}, 32'd1);
    check("to_empty", {31'd0, empty}, 32'd1);
    repeat (6) @(negedge sys_clk);
    busy_mode = 0;
    clr_err = 1'b1;
    @(negedge sys_clk);
    clr_err = 1'b0;
    check("to_cleared", {31'd0, timeout_err}, 32'd0);
    exp_q.push_back(8'h5A);
    put(8'h5A);
    wait_idle("to_recover");

    // reset while a frame is in flight with bytes still queued
    for (int i = 0; i < 6; i++) begin
      d = 8'(8'hC0 + i);
      exp_q.push_back(d);
      put(d);
    end
    n = 0;
    while (!tx_active && n < 100) begin
      @(negedge sys_clk);
      n++;
    end
    repeat (3) @(negedge sys_clk);
    check("mr_count_before", {27'd0, count}, 32'd5);
    sys_rst = 1'b1;
    #1;
    check("mr_en", {31'd0, uart_en}, 32'd0);
    check("mr_count", {27'd0, count}, 32'd0);
    check("mr_empty", {31'd0, empty}, 32'd1);
    while (exp_q.size() > 1) d = exp_q.pop_back();
    repeat (3) @(negedge sys_clk);
    sys_rst = 1'b0;
    wait_idle("mr_drain");
    repeat (400) @(negedge sys_clk);
    check("mr_end_empty", {31'd0, empty}, 32'd1);
    check("mr_end_en", {31'd0, uart_en}, 32'd0);
    check("mr_no_left", exp_q.size(), 32'd0);

    check("max_count", {31'd0, max_count <= DEPTH}, 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
